icon_compositor: RTL

//  Final pixel stage downstream of the Rojobot icon renderer. Merges the 12-bit icon

---
 rtl/icon_compositor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/icon_compositor.sv
`default_nettype none
// ============================================================================
// Module  : icon_compositor
// Brief   : Merges the icon over the world map, aligns VGA syncs, and runs the
//           frame-synchronous hit-flash colour inversion.
// Revision: 1.0 - initial release
// ============================================================================
module icon_compositor #(
  parameter int          ICON_LATENCY = 1,
  parameter int          FLASH_FRAMES = 30,
  parameter int          FLASH_PERIOD = 4,
  parameter logic [11:0] COLOR_BG     = 12'hFFF,
  parameter logic [11:0] COLOR_LINE   = 12'h000,
  parameter logic [11:0] COLOR_OBST   = 12'hF00,
  parameter logic [11:0] COLOR_RSVD   = 12'h0F0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  world_pixel,
  input  logic [11:0] icon,
  input  logic        flash_req,
  output logic [11:0] vga_color,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        flashing
);

  localparam int c_FW = $clog2(FLASH_FRAMES + 1);
  localparam int c_PW = $clog2(FLASH_PERIOD + 1);
  localparam logic [c_FW-1:0] c_FRAMES = c_FW'(FLASH_FRAMES);
  localparam logic [c_PW-1:0] c_PERIOD = c_PW'(FLASH_PERIOD);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_OFF     = 2'd3;
  // Delay-line word layout: {video_on, hsync, vsync, world[1:0]}
  localparam logic [4:0] c_DLY_RST = 5'b01100;

  logic [4:0]      r_dly [ICON_LATENCY];
  logic [4:0]      w_dly_out;
  logic            r_vs_prev;
  logic            w_frame_tick;
  logic [1:0]      r_state, w_state_nxt;
  logic [c_FW-1:0] r_frames_left, w_frames_nxt;
  logic [c_PW-1:0] r_phase, w_phase_nxt;
  logic            r_pend, w_pend_nxt;
  logic            w_flash_on;
  logic [11:0]     w_icon_inv;
  logic [11:0]     w_palette;
  logic [11:0]     w_color;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ICON_LATENCY; i++) r_dly[i] <= c_DLY_RST;
    end else begin
      r_dly[0] <= {video_on, hsync_in, vsync_in, world_pixel};
      for (int i = 1; i < ICON_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_dly_out = r_dly[ICON_LATENCY-1];

  // Tick on the raw vsync fall so the FSM updates as early as possible in blanking
  always_ff @(posedge clk) begin
    if (reset) r_vs_prev <= 1'b1;
    else       r_vs_prev <= vsync_in;
  end

  assign w_frame_tick = r_vs_prev & ~vsync_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_frames_left <= '0;
      r_phase       <= '0;
      r_pend        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frames_left <= w_frames_nxt;
      r_phase       <= w_phase_nxt;
      r_pend        <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frames_nxt = r_frames_left;
    w_phase_nxt  = r_phase;
    w_pend_nxt   = r_pend;
    case (r_state)
      S_IDLE: begin
        w_pend_nxt = 1'b0;
        if (flash_req) w_state_nxt = S_PENDING;
      end
      S_PENDING: begin
        if (w_frame_tick) begin
          w_state_nxt  = S_ON;
          w_frames_nxt = c_FRAMES;
          w_phase_nxt  = '0;
        end
      end
      default: begin
        if (w_frame_tick) begin
          w_pend_nxt = 1'b0;
          // A retrigger outranks both expiry and the half-phase toggle
          if (r_pend || flash_req) begin
            w_state_nxt  = S_ON;
            w_frames_nxt = c_FRAMES;
            w_phase_nxt  = '0;
          end else if (r_frames_left == c_FW'(1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_frames_nxt = r_frames_left - c_FW'(1);
            if ((r_phase + c_PW'(1)) == c_PERIOD) begin
              w_state_nxt = (r_state == S_ON) ? S_OFF : S_ON;
              w_phase_nxt = '0;
            end else begin
              w_phase_nxt = r_phase + c_PW'(1);
            end
          end
        end else if (flash_req) begin
          w_pend_nxt = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    flashing   = (r_state == S_ON) || (r_state == S_OFF);
    w_flash_on = (r_state == S_ON);
  end

  always_comb begin
    w_icon_inv = ~icon;
    case (w_dly_out[1:0])
      2'b00:   w_palette = COLOR_BG;
      2'b01:   w_palette = COLOR_LINE;
      2'b10:   w_palette = COLOR_OBST;
      default: w_palette = COLOR_RSVD;
    endcase
    // An inverted white icon must not collapse into the transparent code
    if (!w_dly_out[4])                      w_color = 12'h000;
    else if ((icon != 12'h000) && w_flash_on) w_color = (w_icon_inv == 12'h000) ? 12'h001 : w_icon_inv;
    else if (icon != 12'h000)               w_color = icon;
    else                                    w_color = w_palette;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_color <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vga_color <= w_color;
      hsync_out <= w_dly_out[3];
      vsync_out <= w_dly_out[2];
    end
  end

endmodule
`default_nettype wire
